// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sample path and its consumers.
package fir_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned PwmWDefault    = 8;
  localparam int unsigned AvgLog2Default = 4;

  // Two's complement to offset-binary: invert the MSB of a w-bit value.
  function automatic logic [31:0] offset_bin(input logic [31:0] v, input int unsigned w);
    return v ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM with duty latched at the period wrap and registered outputs.
module pwm_gen #(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PWM_W-1:0] duty_pending,
  output logic             pwm_out,
  output logic             period_tick,
  output logic [PWM_W-1:0] duty_cur
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;
  logic             wrap;

  always_comb begin
    wrap   = (cnt_q == '1);
    cnt_d  = enable ? cnt_q + 1'b1 : '0;
    // While disabled the duty tracks the pending value so a restart uses the latest one.
    duty_d = (!enable || wrap) ? duty_pending : duty_q;
    pwm_d  = enable && (cnt_q < duty_q);
    tick_d = enable && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      tick_q <= tick_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign duty_cur    = duty_q;

endmodule

// File: rtl/fir_pwm_sink.sv
// FIR stream consumer: block-averages offset-binary samples and drives a PWM from the average.
module fir_pwm_sink
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W   = $bits(sample_t),
  parameter int unsigned PWM_W    = PwmWDefault,
  parameter int unsigned AVG_LOG2 = AvgLog2Default
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              enable,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [PWM_W-1:0]  duty_cur,
  output logic              avg_valid,
  output logic [DATA_W-1:0] avg_sample
);

  localparam int unsigned AccW = DATA_W + AVG_LOG2;
  localparam int unsigned CntW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'((1 << AVG_LOG2) - 1);
  localparam logic [PWM_W-1:0] DutyMid = {1'b1, {(PWM_W - 1){1'b0}}};

  logic [AccW-1:0]   acc_q, acc_d, acc_sum;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] u;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic [PWM_W-1:0]  duty_pending_q, duty_pending_d;

  always_comb begin
    u              = DATA_W'(offset_bin(32'(in_sample), DATA_W));
    acc_sum        = acc_q + AccW'(u);
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    avg_d          = avg_q;
    duty_pending_d = duty_pending_q;
    avg_valid_d    = 1'b0;
    if (in_valid) begin
      if (cnt_q == CntLast) begin
        acc_d          = '0;
        cnt_d          = '0;
        avg_d          = DATA_W'(acc_sum >> AVG_LOG2);
        duty_pending_d = avg_d[DATA_W-1 -: PWM_W];
        avg_valid_d    = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q          <= '0;
      cnt_q          <= '0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      duty_pending_q <= DutyMid;
    end else begin
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      duty_pending_q <= duty_pending_d;
    end
  end

  assign avg_valid  = avg_valid_q;
  assign avg_sample = avg_q;

  pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .duty_pending(duty_pending_q),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .duty_cur    (duty_cur)
  );

endmodule

// File: tb/tb_fir_pwm_sink.sv
// Self-checking bench for fir_pwm_sink: cycle model, vector table and hand-timed corner cases.
module tb_fir_pwm_sink;

  localparam int Avg    = 16;
  localparam int Period = 256;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, enable;
  logic [15:0] in_sample;
  logic        pwm_out, period_tick, avg_valid;
  logic [7:0]  duty_cur;
  logic [15:0] avg_sample;

  always #5 clk = ~clk;

  fir_pwm_sink dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .enable     (enable),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .duty_cur   (duty_cur),
    .avg_valid  (avg_valid),
    .avg_sample (avg_sample)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, expressed in plain arithmetic.
  int          m_blk[$];
  logic [15:0] m_avg;
  logic        m_avg_valid, m_pwm, m_tick;
  int          m_pend, m_phase, m_duty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic rv, input logic iv, input logic [15:0] s,
                            input logic en);
    int new_pend;
    int sum;
    if (!rv) begin
      m_blk.delete();
      m_avg = 0; m_avg_valid = 0; m_pend = 128; m_phase = 0; m_duty = 0;
      m_pwm = 0; m_tick = 0;
      return;
    end
    new_pend    = m_pend;
    m_avg_valid = 0;
    if (iv) begin
      m_blk.push_back(int'(s ^ 16'h8000));
      if (m_blk.size() == Avg) begin
        sum = 0;
        foreach (m_blk[i]) sum += m_blk[i];
        m_avg       = 16'(sum / Avg);
        m_avg_valid = 1;
        new_pend    = int'(m_avg) / 256;
        m_blk.delete();
      end
    end
    m_pwm  = en && (m_phase < m_duty);
    m_tick = en && (m_phase == 0);
    if (!en) begin
      m_duty  = m_pend;
      m_phase = 0;
    end else begin
      if (m_phase == Period - 1) m_duty = m_pend;
      m_phase = (m_phase + 1) % Period;
    end
    m_pend = new_pend;
  endtask

  task automatic step(input logic rv, input logic iv, input logic [15:0] s, input logic en);
    @(negedge clk);
    rst_n = rv; in_valid = iv; in_sample = s; enable = en;
    @(posedge clk);
    model_edge(rv, iv, s, en);
    #1;
    chk("cycle_model", {pwm_out, period_tick, duty_cur, avg_valid, avg_sample},
        {m_pwm, m_tick, 8'(m_duty), m_avg_valid, m_avg});
  endtask

  task automatic feed(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, s, 1'b1);
  endtask

  task automatic find_tick();
    int guard = 0;
    step(1'b1, 1'b0, 16'h0, 1'b1);
    while (!period_tick && guard < 600) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      guard++;
    end
    chk("tick_found", period_tick, 1'b1);
  endtask

  // Observes one full period starting at its tick cycle.
  task automatic measure(output int highs, output int ticks, output logic first_pwm,
                         output logic [7:0] duty);
    find_tick();
    first_pwm = pwm_out;
    duty      = duty_cur;
    highs     = int'(pwm_out);
    ticks     = 1;
    for (int i = 1; i < Period; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      highs += int'(pwm_out);
      ticks += int'(period_tick);
    end
  endtask

  typedef struct {
    logic [15:0] sa;
    int          na;
    logic [15:0] sb;
    int          nb;
    logic [15:0] exp_avg;
    logic [7:0]  exp_duty;
    int          exp_high;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h, t;
    logic        fp, early, en_r;
    logic [7:0]  d;
    logic [15:0] s;

    vecs[0] = '{16'h7FFF, 16, 16'h0000, 0, 16'hFFFF, 8'hFF, 255};
    vecs[1] = '{16'h8000, 16, 16'h0000, 0, 16'h0000, 8'h00, 0};
    vecs[2] = '{16'h7FFF, 8,  16'h8000, 8, 16'h7FFF, 8'h7F, 127};
    vecs[3] = '{16'h0000, 16, 16'h0000, 0, 16'h8000, 8'h80, 128};

    // Reset state
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_pwm_out", pwm_out, 1'b0);
    chk("rst_period_tick", period_tick, 1'b0);
    chk("rst_duty_cur", duty_cur, 8'h00);
    chk("rst_avg_valid", avg_valid, 1'b0);
    chk("rst_avg_sample", avg_sample, 16'h0000);

    // Enabled with no samples: midscale duty after the first wrap
    measure(h, t, fp, d);
    chk("t1_first_period_duty", d, 8'h00);
    measure(h, t, fp, d);
    chk("t1_duty", d, 8'h80);
    chk("t1_highs", h, 128);
    chk("t1_ticks", t, 1);
    chk("t1_tick_on_first_high", fp, 1'b1);

    foreach (vecs[k]) begin
      feed(vecs[k].sa, vecs[k].na);
      feed(vecs[k].sb, vecs[k].nb);
      chk($sformatf("vec%0d_avg_valid", k), avg_valid, 1'b1);
      chk($sformatf("vec%0d_avg_sample", k), avg_sample, vecs[k].exp_avg);
      measure(h, t, fp, d);
      measure(h, t, fp, d);
      chk($sformatf("vec%0d_duty", k), d, vecs[k].exp_duty);
      chk($sformatf("vec%0d_highs", k), h, vecs[k].exp_high);
      chk($sformatf("vec%0d_ticks", k), t, 1);
    end

    // Reset mid-accumulation discards the partial block
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'($urandom), 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t5_rst_avg_sample", avg_sample, 16'h0000);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 16'h4000, 1'b1);
      early |= avg_valid;
    end
    chk("t5_no_early_avg", early, 1'b0);
    step(1'b1, 1'b1, 16'h4000, 1'b1);
    chk("t5_avg_valid", avg_valid, 1'b1);
    chk("t5_avg_sample", avg_sample, 16'hC000);
    measure(h, t, fp, d);
    measure(h, t, fp, d);
    chk("t5_duty", d, 8'hC0);
    chk("t5_highs", h, 192);

    // Average completing on the wrap edge applies one period later
    feed(16'h8000, 15);
    for (int g = 0; g < 600 && m_phase != Period - 1; g++) step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h8000, 1'b1);
    chk("t6_avg_valid", avg_valid, 1'b1);
    chk("t6_wrap_keeps_old_duty", duty_cur, 8'hC0);
    measure(h, t, fp, d);
    chk("t6_old_period_duty", d, 8'hC0);
    chk("t6_old_period_highs", h, 192);
    measure(h, t, fp, d);
    chk("t6_new_period_duty", d, 8'h00);
    chk("t6_new_period_highs", h, 0);

    // Enable deassert mid-period and restart
    feed(16'h0000, 16);
    measure(h, t, fp, d);
    find_tick();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t6_mid_period_high", pwm_out, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_disable_pwm_low", pwm_out, 1'b0);
    chk("t6_disable_tick_low", period_tick, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t6_reenable_tick", period_tick, 1'b1);
    chk("t6_reenable_pwm", pwm_out, 1'b1);
    h = int'(pwm_out);
    t = 1;
    for (int i = 1; i < Period; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1);
      h += int'(pwm_out);
      t += int'(period_tick);
    end
    chk("t6_reenable_highs", h, 128);
    chk("t6_reenable_ticks", t, 1);

    // Randomised traffic against the model
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      case ($urandom_range(0, 3))
        0:       s = 16'h7FFF;
        1:       s = 16'h8000;
        default: s = 16'($urandom);
      endcase
      step(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), s, en_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
